// File: rtl/voice_mixer_pkg.sv
// Shared constants for the N-voice output mixer.
// Mode codes and FSM state encoding.
package voice_mixer_pkg;

    localparam logic [1:0] MODE_SEL = 2'b00;
    localparam logic [1:0] MODE_SUM = 2'b01;
    localparam logic [1:0] MODE_AVG = 2'b10;
    localparam logic [1:0] MODE_RSV = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/voice_mixer_sat_clip.sv
// Saturating clip of a wide accumulator value down to M bits.
// Any set bit above the sample width forces full scale.
module sat_clip #(
    parameter int M  = 12,
    parameter int AW = 14
) (
    input  logic [AW-1:0] acc_i,
    output logic [M-1:0]  clip_o
);

    assign clip_o = (|acc_i[AW-1:M]) ? {M{1'b1}} : acc_i[M-1:0];

endmodule

// File: rtl/voice_mixer.sv
// N-voice output stage: snapshots voices on a strobe, then selects
// one voice or mixes enabled voices through a single shared adder.
module voice_mixer
    import voice_mixer_pkg::*;
#(
    parameter  int M  = 12,
    parameter  int N  = 4,
    localparam int IW = $clog2(N),
    localparam int AW = M + IW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sample_strobe,
    input  logic [N*M-1:0]  voices_in,
    input  logic [N-1:0]    voice_en,
    input  logic [1:0]      mode,
    input  logic [IW-1:0]   sel,
    output logic [M-1:0]    out,
    output logic            out_valid,
    output logic            busy,
    output logic            overrun
);

    localparam logic [IW-1:0] LAST = IW'(N - 1);
    localparam logic [IW:0]   NV   = (IW + 1)'(N);

    state_e           state_q, state_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [N*M-1:0]   snap_v_q, snap_v_d;
    logic [N-1:0]     snap_en_q, snap_en_d;
    logic [1:0]       snap_mode_q, snap_mode_d;
    logic [IW-1:0]    snap_sel_q, snap_sel_d;
    logic [M-1:0]     out_q, out_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;

    logic [M-1:0]     cur_voice;
    logic [IW-1:0]    sel_idx;
    logic [M-1:0]     sel_voice;
    logic [M-1:0]     clip_out;
    logic [M-1:0]     result;

    assign cur_voice = snap_v_q[int'(idx_q) * M +: M];

    // Out-of-range select indices fall back to voice 0
    assign sel_idx   = ({1'b0, snap_sel_q} < NV) ? snap_sel_q : '0;
    assign sel_voice = snap_v_q[int'(sel_idx) * M +: M];

    sat_clip #(
        .M  (M),
        .AW (AW)
    ) u_clip (
        .acc_i  (acc_q),
        .clip_o (clip_out)
    );

    always_comb begin
        result = sel_voice;
        unique case (snap_mode_q)
            MODE_SUM: result = clip_out;
            MODE_AVG: result = acc_q[AW-1:IW];
            default:  result = sel_voice;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        snap_v_d    = snap_v_q;
        snap_en_d   = snap_en_q;
        snap_mode_d = snap_mode_q;
        snap_sel_d  = snap_sel_q;
        out_d       = out_q;
        valid_d     = 1'b0;
        overrun_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sample_strobe) begin
                    state_d     = ACCUM;
                    snap_v_d    = voices_in;
                    snap_en_d   = voice_en;
                    snap_mode_d = mode;
                    snap_sel_d  = sel;
                    acc_d       = '0;
                    idx_d       = '0;
                end
            end
            ACCUM: begin
                overrun_d = sample_strobe;
                if (snap_en_q[idx_q]) begin
                    acc_d = acc_q + AW'(cur_voice);
                end
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                overrun_d = sample_strobe;
                out_d     = result;
                valid_d   = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            idx_q       <= '0;
            snap_v_q    <= '0;
            snap_en_q   <= '0;
            snap_mode_q <= MODE_SEL;
            snap_sel_q  <= '0;
            out_q       <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            snap_v_q    <= snap_v_d;
            snap_en_q   <= snap_en_d;
            snap_mode_q <= snap_mode_d;
            snap_sel_q  <= snap_sel_d;
            out_q       <= out_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;
    assign busy      = (state_q != IDLE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_voice_mixer.sv
// Self-checking bench for voice_mixer (N=4 main instance, N=3 side
// instance) against a plain-arithmetic reference model.
module tb_voice_mixer;

    localparam int M = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // N=4 instance
    logic         strobe4;
    logic [47:0]  vin4;
    logic [3:0]   en4;
    logic [1:0]   mode4;
    logic [1:0]   sel4;
    logic [11:0]  out4;
    logic         valid4, busy4, ovr4;

    // N=3 instance
    logic         strobe3;
    logic [35:0]  vin3;
    logic [2:0]   en3;
    logic [1:0]   mode3;
    logic [1:0]   sel3;
    logic [11:0]  out3;
    logic         valid3, busy3, ovr3;

    voice_mixer #(.M(12), .N(4)) dut4 (
        .clk           (clk),
        .rst           (rst),
        .sample_strobe (strobe4),
        .voices_in     (vin4),
        .voice_en      (en4),
        .mode          (mode4),
        .sel           (sel4),
        .out           (out4),
        .out_valid     (valid4),
        .busy          (busy4),
        .overrun       (ovr4)
    );

    voice_mixer #(.M(12), .N(3)) dut3 (
        .clk           (clk),
        .rst           (rst),
        .sample_strobe (strobe3),
        .voices_in     (vin3),
        .voice_en      (en3),
        .mode          (mode3),
        .sel           (sel3),
        .out           (out3),
        .out_valid     (valid3),
        .busy          (busy3),
        .overrun       (ovr3)
    );

    int errors = 0;
    int checks = 0;
    int v[16];
    int w[16];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: sum of enabled voices, clipped or divided by 2^clog2(n)
    function automatic int model(input int n, input int vv[16],
                                 input int en, input int md,
                                 input int sl);
        int sum;
        int div;
        sum = 0;
        for (int i = 0; i < n; i++)
            if (((en >> i) & 1) == 1) sum += vv[i];
        div = 1;
        while (div < n) div = div * 2;
        if (md == 1) return (sum > 4095) ? 4095 : sum;
        if (md == 2) return sum / div;
        return (sl < n) ? vv[sl] : vv[0];
    endfunction

    task automatic pack4();
        for (int i = 0; i < 4; i++) vin4[i*12 +: 12] = v[i][11:0];
    endtask

    task automatic pack3();
        for (int i = 0; i < 3; i++) vin3[i*12 +: 12] = w[i][11:0];
    endtask

    // One transaction on the N=4 instance, cycle-exact checks
    task automatic mix4(input string tag, input int ovr_at,
                        input bit scramble);
        int exp;
        exp = model(4, v, int'(en4), int'(mode4), int'(sel4));
        @(negedge clk);
        pack4();
        strobe4 = 1'b1;
        @(negedge clk);
        strobe4 = 1'b0;
        chk({tag, ":busy0"}, 32'(busy4), 32'd1);
        if (scramble) begin
            vin4 = '1;
            en4  = ~en4;
        end
        for (int k = 1; k <= 5; k++) begin
            if (k == ovr_at) strobe4 = 1'b1;
            @(negedge clk);
            strobe4 = 1'b0;
            chk($sformatf("%s:busy%0d", tag, k), 32'(busy4),
                32'(k <= 4));
            chk($sformatf("%s:valid%0d", tag, k), 32'(valid4),
                32'(k == 5));
            chk($sformatf("%s:ovr%0d", tag, k), 32'(ovr4),
                32'(k == ovr_at));
        end
        chk({tag, ":out"}, 32'(out4), 32'(exp));
        @(negedge clk);
        chk({tag, ":valid_low"}, 32'(valid4), 32'd0);
        chk({tag, ":hold"}, 32'(out4), 32'(exp));
        pack4();
    endtask

    // One transaction on the N=3 instance, bounded wait for valid
    task automatic mix3(input string tag);
        int exp;
        int lat;
        exp = model(3, w, int'(en3), int'(mode3), int'(sel3));
        @(negedge clk);
        pack3();
        strobe3 = 1'b1;
        @(negedge clk);
        strobe3 = 1'b0;
        lat = 0;
        while (!valid3 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ":lat"}, 32'(lat), 32'd4);
        chk({tag, ":out"}, 32'(out3), 32'(exp));
    endtask

    initial begin
        rst = 1'b1;
        strobe4 = 1'b0; strobe3 = 1'b0;
        en4 = '0; en3 = '0; mode4 = '0; mode3 = '0;
        sel4 = '0; sel3 = '0;
        for (int i = 0; i < 16; i++) begin
            v[i] = 0; w[i] = 0;
        end
        v[0] = 'h100; v[1] = 'h200; v[2] = 'h300; v[3] = 'h400;
        w[0] = 'h100; w[1] = 'h200; w[2] = 'h300;
        pack4();
        pack3();

        // 1. reset and select
        repeat (3) @(negedge clk);
        chk("rst:out", 32'(out4), 32'd0);
        chk("rst:valid", 32'(valid4), 32'd0);
        chk("rst:busy", 32'(busy4), 32'd0);
        chk("rst:ovr", 32'(ovr4), 32'd0);
        rst = 1'b0;
        mode4 = 2'b00; sel4 = 2'd2;
        mix4("sel2", -1, 1'b0);
        chk("sel2:const", 32'(out4), 32'h300);

        // 2. saturating sum
        mode4 = 2'b01; en4 = 4'b1111;
        mix4("sum_all", -1, 1'b0);
        chk("sum_all:const", 32'(out4), 32'hA00);
        v[0] = 'hFFF; v[1] = 'h800; en4 = 4'b0011;
        mix4("sum_sat", -1, 1'b0);
        chk("sum_sat:const", 32'(out4), 32'hFFF);
        en4 = 4'b0000;
        mix4("sum_none", -1, 1'b0);
        chk("sum_none:const", 32'(out4), 32'h000);

        // 3. average
        for (int i = 0; i < 4; i++) v[i] = 'h400;
        mode4 = 2'b10; en4 = 4'b1111;
        mix4("avg_all", -1, 1'b0);
        chk("avg_all:const", 32'(out4), 32'h400);
        en4 = 4'b0001;
        mix4("avg_one", -1, 1'b0);
        chk("avg_one:const", 32'(out4), 32'h100);

        // 4. snapshot isolation and dropped strobe
        v[0] = 'h100; v[1] = 'h200; v[2] = 'h300; v[3] = 'h400;
        mode4 = 2'b01; en4 = 4'b1111;
        mix4("snap_ovr", 2, 1'b1);
        chk("snap_ovr:const", 32'(out4), 32'hA00);

        // 5. reset in the third accumulate cycle
        mode4 = 2'b01; en4 = 4'b1111;
        @(negedge clk);
        strobe4 = 1'b1;
        @(negedge clk);
        strobe4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst:out", 32'(out4), 32'd0);
        chk("midrst:busy", 32'(busy4), 32'd0);
        chk("midrst:valid", 32'(valid4), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("midrst:novalid%0d", k), 32'(valid4), 32'd0);
        end
        chk("midrst:out_after", 32'(out4), 32'd0);
        mode4 = 2'b00; sel4 = 2'd1;
        mix4("post_rst", -1, 1'b0);
        chk("post_rst:const", 32'(out4), 32'h200);

        // 6. non-power-of-2 instance
        mode3 = 2'b00; sel3 = 2'd3;
        mix3("n3_sel3");
        chk("n3_sel3:const", 32'(out3), 32'h100);
        mode3 = 2'b11; sel3 = 2'd1;
        mix3("n3_rsv");
        chk("n3_rsv:const", 32'(out3), 32'h200);

        // randomized transactions on both instances
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < 4; i++) v[i] = int'($urandom_range(0, 4095));
            for (int i = 0; i < 3; i++) w[i] = int'($urandom_range(0, 4095));
            en4   = 4'($urandom);
            mode4 = 2'($urandom);
            sel4  = 2'($urandom);
            en3   = 3'($urandom);
            mode3 = 2'($urandom);
            sel3  = 2'($urandom);
            mix4($sformatf("rnd%0d", t),
                 (t % 3 == 0) ? int'($urandom_range(1, 5)) : -1,
                 1'(t % 2));
            mix3($sformatf("rnd3_%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
